// File: rtl/text_stream_writer.sv
// ----------------------------------------------------------------------------
// text_stream_writer
//
// Terminal-style writer for a VGA text display. It takes a byte stream
// (character + colour attribute) over a valid/ready handshake, interprets a
// few control codes and keeps a row/column cursor. Results go out as
// single-cycle writes to the character and colour page memories. A write is
// only issued after a clock edge that sampled disp low, so it never collides
// with scan-out reads.
//
// Control codes:
//   0x0D CR  - column to 0, no write
//   0x0A LF  - column to 0, next row (wraps at the bottom), no write
//   0x08 BS  - cursor back one cell (stops at cell 0), then write a space there
//   0x0C FF  - clear the whole page to spaces with CLEAR_ATTR, cursor home
//   other    - write the byte at the cursor, then advance (wraps, no scroll)
//
// Ports:
//   CLOCK_50    in   system clock, all logic on the rising edge
//   resetn      in   asynchronous active-low reset
//   in_valid    in   input byte present
//   in_ready    out  writer can accept a byte (idle)
//   in_char     in   ASCII byte
//   in_attr     in   colour attribute for in_char
//   disp        in   display active; page memories are busy while high
//   wr_addr     out  page memory address
//   wr_char     out  data for the character page
//   wr_attr     out  data for the colour page
//   wr_en       out  write strobe for both pages, one cycle per write
//   cursor_pos  out  row*COLS+col of the current cursor
//   busy        out  high whenever the writer is not idle
//
// Timing: a byte accepted on edge N is written with the strobe visible after
// edge N+2 (disp low throughout); in_ready returns in that same cycle. CR and
// LF return to ready right after edge N+1.
// ----------------------------------------------------------------------------
module text_stream_writer #(
  parameter int              COLS       = 80,
  parameter int              ROWS       = 60,
  parameter int              ADDR_W     = 13,
  parameter logic [7:0]      CLEAR_ATTR = 8'h0F
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  input  logic              disp,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [7:0]        wr_attr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] cursor_pos,
  output logic              busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_CLEAR
  } state_e;

  state_e            state_q,      state_d;
  logic [ROW_W-1:0]  row_q,        row_d;
  logic [COL_W-1:0]  col_q,        col_d;
  logic [ADDR_W-1:0] cursor_pos_q, cursor_pos_d;
  logic [7:0]        char_q,       char_d;
  logic [7:0]        attr_q,       attr_d;
  logic              advance_q,    advance_d;   // printable: step cursor after the write
  logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
  logic              wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [7:0]        wr_char_q,    wr_char_d;
  logic [7:0]        wr_attr_q,    wr_attr_d;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    char_d    = char_q;
    attr_d    = attr_q;
    advance_d = advance_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;          // strobe is a single-cycle pulse
    wr_addr_d = wr_addr_q;
    wr_char_d = wr_char_q;
    wr_attr_d = wr_attr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          char_d  = in_char;
          attr_d  = in_attr;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (char_q)
          CH_CR: begin
            col_d   = '0;
            state_d = ST_IDLE;
          end
          CH_LF: begin
            col_d   = '0;
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            state_d = ST_IDLE;
          end
          CH_BS: begin
            // Step back across the row boundary; cell 0 stays put.
            if (col_q != '0) begin
              col_d = col_q - COL_W'(1);
            end else if (row_q != '0) begin
              row_d = row_q - ROW_W'(1);
              col_d = LAST_COL;
            end
            char_d    = CH_SPACE;
            advance_d = 1'b0;
            state_d   = ST_WRITE;
          end
          CH_FF: begin
            clr_cnt_d = '0;
            state_d   = ST_CLEAR;
          end
          default: begin
            advance_d = 1'b1;
            state_d   = ST_WRITE;
          end
        endcase
      end

      ST_WRITE: begin
        if (!disp) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cursor_pos_q;
          wr_char_d = char_q;
          wr_attr_d = attr_q;
          if (advance_q) begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (!disp) begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q;
          wr_char_d = CH_SPACE;
          wr_attr_d = CLEAR_ATTR;
          if (clr_cnt_q == LAST_ADDR) begin
            row_d   = '0;
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Linear address follows row/col so cursor_pos changes on the same edge.
    cursor_pos_d = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      cursor_pos_q <= '0;
      char_q       <= '0;
      attr_q       <= '0;
      advance_q    <= 1'b0;
      clr_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_char_q    <= '0;
      wr_attr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cursor_pos_q <= cursor_pos_d;
      char_q       <= char_d;
      attr_q       <= attr_d;
      advance_q    <= advance_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_char_q    <= wr_char_d;
      wr_attr_q    <= wr_attr_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_char    = wr_char_q;
  assign wr_attr    = wr_attr_q;
  assign cursor_pos = cursor_pos_q;

endmodule

// File: tb/tb_text_stream_writer.sv
// ----------------------------------------------------------------------------
// tb_text_stream_writer
//
// Self-checking bench for text_stream_writer. The reference model keeps the
// cursor as a single linear cell index and predicts the page writes each byte
// must produce. A negedge monitor pops predictions and compares every strobe,
// and also flags any strobe that follows an edge where disp was high.
// ----------------------------------------------------------------------------
module tb_text_stream_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;

  logic              CLOCK_50 = 1'b0;
  logic              resetn   = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_char  = 8'h00;
  logic [7:0]        in_attr  = 8'h00;
  logic              disp     = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic [7:0]        wr_attr;
  logic              wr_en;
  logic [ADDR_W-1:0] cursor_pos;
  logic              busy;

  text_stream_writer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .ADDR_W    (ADDR_W),
    .CLEAR_ATTR(8'h0F)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_attr   (in_attr),
    .disp      (disp),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .wr_attr   (wr_attr),
    .wr_en     (wr_en),
    .cursor_pos(cursor_pos),
    .busy      (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        ch;
    logic [7:0]        at;
  } wr_t;

  int   checks      = 0;
  int   failures    = 0;
  int   write_count = 0;
  int   m_pos       = 0;     // model cursor, linear cell index
  wr_t  exp_q[$];
  wr_t  mon_e;

  // disp driver: 0 = low, 1 = high, 2 = random per cycle, 3 = toggle every 16
  int   disp_mode = 0;
  int   tog_cnt   = 0;
  logic disp_last = 1'b0;

  always @(negedge CLOCK_50) begin
    case (disp_mode)
      0: disp = 1'b0;
      1: disp = 1'b1;
      2: disp = 1'($urandom_range(0, 1));
      default: begin
        if (tog_cnt == 15) begin
          disp    = ~disp;
          tog_cnt = 0;
        end else begin
          tog_cnt++;
        end
      end
    endcase
  end

  always @(posedge CLOCK_50) disp_last = disp;

  // Write monitor / scoreboard
  always @(negedge CLOCK_50) begin
    if (wr_en === 1'b1) begin
      write_count++;
      checks++;
      if (disp_last !== 1'b0) begin
        failures++;
        if (failures <= 20)
          $display("FAIL disp_guard: write at addr %0d follows disp=%b, required disp=0",
                   wr_addr, disp_last);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        if (failures <= 20)
          $display("FAIL unexpected_write: got addr=%0d char=%h attr=%h, required no write",
                   wr_addr, wr_char, wr_attr);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_char !== mon_e.ch || wr_attr !== mon_e.at) begin
          failures++;
          if (failures <= 20)
            $display("FAIL write_data: got addr=%0d char=%h attr=%h, required addr=%0d char=%h attr=%h",
                     wr_addr, wr_char, wr_attr, mon_e.addr, mon_e.ch, mon_e.at);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: predicts writes and the cursor from the byte alone
  // --------------------------------------------------------------------------
  task automatic model_byte(input logic [7:0] ch, input logic [7:0] at);
    wr_t w;
    case (ch)
      8'h0D: m_pos = (m_pos / COLS) * COLS;
      8'h0A: m_pos = (((m_pos / COLS) + 1) % ROWS) * COLS;
      8'h08: begin
        if (m_pos > 0) m_pos = m_pos - 1;
        w.addr = ADDR_W'(m_pos); w.ch = 8'h20; w.at = at;
        exp_q.push_back(w);
      end
      8'h0C: begin
        for (int i = 0; i < CELLS; i++) begin
          w.addr = ADDR_W'(i); w.ch = 8'h20; w.at = 8'h0F;
          exp_q.push_back(w);
        end
        m_pos = 0;
      end
      default: begin
        w.addr = ADDR_W'(m_pos); w.ch = ch; w.at = at;
        exp_q.push_back(w);
        m_pos = (m_pos + 1) % CELLS;
      end
    endcase
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    exp_q.delete();
    m_pos = 0;
    @(negedge CLOCK_50);
  endtask

  // Returns at the negedge after the accepting edge (writer is executing).
  task automatic send_byte(input logic [7:0] ch, input logic [7:0] at);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (in_ready !== 1'b1 && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    model_byte(ch, at);
    in_valid = 1'b1;
    in_char  = ch;
    in_attr  = at;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_timeout: in_ready=%b, required 1", in_ready);
    end
    #1;
  endtask

  task automatic send_wait(input logic [7:0] ch, input logic [7:0] at);
    send_byte(ch, at);
    wait_idle();
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    disp_mode = 0;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({wr_en, busy, cursor_pos, wr_addr, wr_char, wr_attr} !==
        {1'b0, 1'b0, 13'd0, 13'd0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_outputs: wr_en=%b busy=%b cursor=%0d addr=%0d char=%h attr=%h, required all zero",
               wr_en, busy, cursor_pos, wr_addr, wr_char, wr_attr);
    end
    resetn = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
    exp_q.delete();
    m_pos = 0;
  endtask

  task automatic test_single_write();
    do_reset();
    send_byte(8'h41, 8'h1E);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_busy: in_ready=%b busy=%b, required 0/1", in_ready, busy);
    end
    @(negedge CLOCK_50);
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL early_strobe: wr_en=%b in_ready=%b, required 0/0", wr_en, in_ready);
    end
    @(negedge CLOCK_50);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_char, wr_attr, in_ready, cursor_pos} !==
        {1'b1, 13'd0, 8'h41, 8'h1E, 1'b1, 13'd1}) begin
      failures++;
      $display("FAIL first_write: wr_en=%b addr=%0d char=%h attr=%h ready=%b cursor=%0d, required 1/0/41/1e/1/1",
               wr_en, wr_addr, wr_char, wr_attr, in_ready, cursor_pos);
    end
    @(negedge CLOCK_50);
    checks++;
    if (wr_en !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_pulse: wr_en=%b pending=%0d, required 0/0", wr_en, exp_q.size());
    end
  endtask

  task automatic test_disp_hold();
    bit bad;
    bad = 1'b0;
    disp_mode = 1;
    send_byte(8'h42, 8'h2A);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (wr_en !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL disp_hold: wr_en=%b busy=%b during disp=1, required 0/1", wr_en, busy);
    end
    disp_mode = 0;
    wait_idle();
    checks++;
    if (cursor_pos !== ADDR_W'(m_pos) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL disp_release: cursor=%0d pending=%0d, required %0d/0",
               cursor_pos, exp_q.size(), m_pos);
    end
  endtask

  task automatic test_lf_cr();
    int wc;
    do_reset();
    send_wait(8'h0A, 8'h07);
    send_wait(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) send_wait(8'h61 + 8'(i), 8'h07);
    checks++;
    if (cursor_pos !== 13'd165) begin
      failures++;
      $display("FAIL cursor_165: cursor=%0d, required 165", cursor_pos);
    end
    wc = write_count;
    send_byte(8'h0A, 8'h07);
    @(negedge CLOCK_50);
    checks++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0 || cursor_pos !== 13'd240) begin
      failures++;
      $display("FAIL lf_exec: ready=%b wr_en=%b cursor=%0d, required 1/0/240",
               in_ready, wr_en, cursor_pos);
    end
    for (int i = 0; i < 7; i++) send_wait(8'h70 + 8'(i), 8'h35);
    send_byte(8'h0D, 8'h07);
    @(negedge CLOCK_50);
    checks++;
    if (in_ready !== 1'b1 || cursor_pos !== 13'd240 || write_count != wc + 7) begin
      failures++;
      $display("FAIL cr_exec: ready=%b cursor=%0d writes=%0d, required 1/240/%0d",
               in_ready, cursor_pos, write_count - wc, 7);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send_wait(8'h0A, 8'h00);
    for (int i = 0; i < COLS - 1; i++) send_wait(8'h2E, 8'h11);
    checks++;
    if (cursor_pos !== 13'd4799) begin
      failures++;
      $display("FAIL cursor_last: cursor=%0d, required 4799", cursor_pos);
    end
    send_wait(8'h5A, 8'h3C);
    checks++;
    if (cursor_pos !== 13'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL last_cell_wrap: cursor=%0d pending=%0d, required 0/0", cursor_pos, exp_q.size());
    end
    send_wait(8'h0A, 8'h00);
    send_wait(8'h08, 8'h5B);
    checks++;
    if (cursor_pos !== 13'd79 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bs_row_wrap: cursor=%0d pending=%0d, required 79/0", cursor_pos, exp_q.size());
    end
    send_wait(8'h0D, 8'h00);
    send_wait(8'h08, 8'h6C);
    checks++;
    if (cursor_pos !== 13'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bs_home: cursor=%0d pending=%0d, required 0/0", cursor_pos, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] ch;
    do_reset();
    disp_mode = 2;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: ch = 8'h0D;
        1: ch = 8'h0A;
        2: ch = 8'h08;
        default: begin
          ch = 8'($urandom_range(0, 255));
          if (ch == 8'h0C) ch = 8'h7E;
        end
      endcase
      send_wait(ch, 8'($urandom_range(0, 255)));
      checks++;
      if (cursor_pos !== ADDR_W'(m_pos) || exp_q.size() != 0) begin
        failures++;
        $display("FAIL random_step%0d: byte=%h cursor=%0d pending=%0d, required %0d/0",
                 i, ch, cursor_pos, exp_q.size(), m_pos);
      end
    end
    disp_mode = 0;
  endtask

  task automatic test_clear();
    int wc;
    send_wait(8'h47, 8'h12);    // move the cursor off home first
    wc = write_count;
    disp_mode = 3;
    send_wait(8'h0C, 8'h99);
    disp_mode = 0;
    checks++;
    if (write_count - wc != CELLS + 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clear_count: writes=%0d pending=%0d, required %0d/0",
               write_count - wc, exp_q.size(), CELLS);
    end
    checks++;
    if (cursor_pos !== 13'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_home: cursor=%0d ready=%b, required 0/1", cursor_pos, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int wc;
    do_reset();
    send_byte(8'h0C, 8'h00);
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === 13'd1000) && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (!(wr_en === 1'b1 && wr_addr === 13'd1000)) begin
      failures++;
      $display("FAIL abort_reach: wr_en=%b addr=%0d, required 1/1000", wr_en, wr_addr);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, in_ready, cursor_pos} !== {1'b0, 1'b0, 1'b1, 13'd0}) begin
      failures++;
      $display("FAIL abort_reset: wr_en=%b busy=%b ready=%b cursor=%0d, required 0/0/1/0",
               wr_en, busy, in_ready, cursor_pos);
    end
    exp_q.delete();
    m_pos = 0;
    wc = write_count;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    checks++;
    if (write_count != wc) begin
      failures++;
      $display("FAIL abort_quiet: writes=%0d during reset, required 0", write_count - wc);
    end
    send_wait(8'h33, 8'h44);
    checks++;
    if (cursor_pos !== 13'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_resume: cursor=%0d pending=%0d, required 1/0", cursor_pos, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_disp_hold();
    test_lf_cr();
    test_boundaries();
    test_random();
    test_clear();
    test_reset_abort();
    repeat (2) @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
